// File: rtl/rtc_clock_core_if.sv
// Bus bundle for the timekeeping core: control/load/alarm inputs and the
// time display plus event pulse outputs. Clock and reset stay plain ports.
interface rtc_clock_core_if;
    // Control and load
    logic       run;
    logic       mode24;
    logic       set_valid;
    logic [4:0] set_hours;
    logic [5:0] set_minutes;
    logic [5:0] set_seconds;

    // Alarm setting
    logic       alarm_en;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;

    // Time display
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic       isPM;

    // Event pulses
    logic       sec_tick;
    logic       hour_chime;
    logic       day_wrap;
    logic       set_err;
    logic       alarm;

    // Controller side: drives control/load/alarm, observes time and pulses
    modport master (
        output run, mode24, set_valid, set_hours, set_minutes, set_seconds,
        output alarm_en, alarm_hours, alarm_minutes,
        input  seconds, minutes, hours, isPM,
        input  sec_tick, hour_chime, day_wrap, set_err, alarm
    );

    // Core side
    modport slave (
        input  run, mode24, set_valid, set_hours, set_minutes, set_seconds,
        input  alarm_en, alarm_hours, alarm_minutes,
        output seconds, minutes, hours, isPM,
        output sec_tick, hour_chime, day_wrap, set_err, alarm
    );
endinterface

// File: rtl/rtc_clock_core.sv
// Real-time clock core: prescaled seconds/minutes/hours counter kept in
// 24-hour form, with run/pause, validated time load, 12/24-hour display
// mapping and a minute-resolution alarm. All pulses are registered and
// line up with the cycle in which the new time becomes visible.
module rtc_clock_core #(
    parameter int TICKS_PER_SEC = 1000,
    parameter bit DEFAULT_24H   = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    rtc_clock_core_if.slave bus
);

    // A prescaler of width 1 is kept even when one tick per cycle is asked for
    localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [5:0]         sec_q, sec_d;
    logic [5:0]         min_q, min_d;
    logic [4:0]         hour_q, hour_d;
    logic               mode_q;

    logic               sec_tick_q,   sec_tick_d;
    logic               hour_chime_q, hour_chime_d;
    logic               day_wrap_q,   day_wrap_d;
    logic               set_err_q,    set_err_d;
    logic               alarm_q,      alarm_d;

    // ------------------------------------------------------------------
    // Decode of tick and load requests
    // ------------------------------------------------------------------
    logic tick;
    logic load_in_range;
    logic load_ok;
    logic load_bad;
    logic sec_wrap;
    logic min_wrap;
    logic hour_wrap;

    assign tick          = bus.run && (presc_q == PRESC_LAST);
    assign load_in_range = (bus.set_hours   <= 5'd23) &&
                           (bus.set_minutes <= 6'd59) &&
                           (bus.set_seconds <= 6'd59);
    assign load_ok       = bus.set_valid &&  load_in_range;
    assign load_bad      = bus.set_valid && !load_in_range;

    // Carry chain of the current time, used by the tick path
    assign sec_wrap  = (sec_q  == 6'd59);
    assign min_wrap  = sec_wrap && (min_q  == 6'd59);
    assign hour_wrap = min_wrap && (hour_q == 5'd23);

    // ------------------------------------------------------------------
    // Next-state: an accepted load wins over a tick; a rejected load only
    // flags an error and leaves the prescaler and tick path untouched.
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch; blocking '=' is correct here
    // because later lines must see the updated next-state values.
    always_comb begin
        presc_d      = presc_q;
        sec_d        = sec_q;
        min_d        = min_q;
        hour_d       = hour_q;
        sec_tick_d   = 1'b0;
        hour_chime_d = 1'b0;
        day_wrap_d   = 1'b0;
        set_err_d    = 1'b0;
        alarm_d      = 1'b0;

        if (load_ok) begin
            presc_d = '0;
            sec_d   = bus.set_seconds;
            min_d   = bus.set_minutes;
            hour_d  = bus.set_hours;
        end else begin
            set_err_d = load_bad;

            if (bus.run) begin
                presc_d = tick ? '0 : presc_q + PRESC_ONE;
            end

            if (tick) begin
                sec_d = sec_wrap ? 6'd0 : sec_q + 6'd1;
                if (sec_wrap) begin
                    min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                end
                if (min_wrap) begin
                    hour_d = hour_wrap ? 5'd0 : hour_q + 5'd1;
                end

                sec_tick_d   = 1'b1;
                hour_chime_d = min_wrap;
                day_wrap_d   = hour_wrap;
                // New time is hh:mm:00 only on a seconds wrap; an alarm
                // setting outside 0..23 / 0..59 can never equal it
                alarm_d      = bus.alarm_en && sec_wrap &&
                               (hour_d == bus.alarm_hours) &&
                               (min_d  == bus.alarm_minutes);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers with synchronous active-high reset
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking '<=' so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q      <= '0;
            sec_q        <= 6'd0;
            min_q        <= 6'd0;
            hour_q       <= 5'd0;
            mode_q       <= DEFAULT_24H;
            sec_tick_q   <= 1'b0;
            hour_chime_q <= 1'b0;
            day_wrap_q   <= 1'b0;
            set_err_q    <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            sec_q        <= sec_d;
            min_q        <= min_d;
            hour_q       <= hour_d;
            mode_q       <= bus.mode24;
            sec_tick_q   <= sec_tick_d;
            hour_chime_q <= hour_chime_d;
            day_wrap_q   <= day_wrap_d;
            set_err_q    <= set_err_d;
            alarm_q      <= alarm_d;
        end
    end

    // ------------------------------------------------------------------
    // Display mapping from registered state
    // ------------------------------------------------------------------
    logic [4:0] hour_mod12;
    logic [4:0] hour_disp;

    // 12-hour form maps 0 and 12 to 12; 24-hour form shows hour24 directly
    always_comb begin
        hour_mod12 = (hour_q >= 5'd12) ? hour_q - 5'd12 : hour_q;
        if (mode_q) begin
            hour_disp = hour_q;
        end else begin
            hour_disp = (hour_mod12 == 5'd0) ? 5'd12 : hour_mod12;
        end
    end

    assign bus.seconds    = sec_q;
    assign bus.minutes    = min_q;
    assign bus.hours      = hour_disp;
    assign bus.isPM       = (hour_q >= 5'd12);
    assign bus.sec_tick   = sec_tick_q;
    assign bus.hour_chime = hour_chime_q;
    assign bus.day_wrap   = day_wrap_q;
    assign bus.set_err    = set_err_q;
    assign bus.alarm      = alarm_q;

endmodule

// File: tb/tb_rtc_clock_core.sv
// Directed bench for rtc_clock_core with TICKS_PER_SEC=4, 12-hour default.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_rtc_clock_core;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic saw_tick;

    rtc_clock_core_if bus ();

    rtc_clock_core #(
        .TICKS_PER_SEC (4),
        .DEFAULT_24H   (1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 ns after the last one
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        bus.set_valid   = 1'b1;
        bus.set_hours   = h;
        bus.set_minutes = m;
        bus.set_seconds = s;
        step(1);
        bus.set_valid   = 1'b0;
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, ".hours"},   32'(bus.hours),   32'(h));
        check({tag, ".minutes"}, 32'(bus.minutes), 32'(m));
        check({tag, ".seconds"}, 32'(bus.seconds), 32'(s));
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        reset             = 1'b1;
        bus.run           = 1'b0;
        bus.mode24        = 1'b0;
        bus.set_valid     = 1'b0;
        bus.set_hours     = 5'd0;
        bus.set_minutes   = 6'd0;
        bus.set_seconds   = 6'd0;
        bus.alarm_en      = 1'b0;
        bus.alarm_hours   = 5'd0;
        bus.alarm_minutes = 6'd0;

        // Reset state
        step(2);
        check_time("rst", 12, 0, 0);
        check("rst.isPM", 32'(bus.isPM), 0);
        check("rst.sec_tick", 32'(bus.sec_tick), 0);
        check("rst.day_wrap", 32'(bus.day_wrap), 0);

        // First ticks: seconds step every 4 edges
        reset   = 1'b0;
        bus.run = 1'b1;
        step(3);
        check("t0.seconds", 32'(bus.seconds), 0);
        check("t0.sec_tick", 32'(bus.sec_tick), 0);
        step(1);
        check("t1.seconds", 32'(bus.seconds), 1);
        check("t1.sec_tick", 32'(bus.sec_tick), 1);
        step(1);
        check("t1.pulse_width", 32'(bus.sec_tick), 0);
        step(3);
        check("t2.seconds", 32'(bus.seconds), 2);
        check("t2.sec_tick", 32'(bus.sec_tick), 1);

        // Day wrap from 23:59:58
        load(5'd23, 6'd59, 6'd58);
        check_time("ld23", 11, 59, 58);
        check("ld23.isPM", 32'(bus.isPM), 1);
        check("ld23.sec_tick", 32'(bus.sec_tick), 0);
        step(4);
        check_time("s59", 11, 59, 59);
        check("s59.hour_chime", 32'(bus.hour_chime), 0);
        step(4);
        check_time("wrap", 12, 0, 0);
        check("wrap.isPM", 32'(bus.isPM), 0);
        check("wrap.day_wrap", 32'(bus.day_wrap), 1);
        check("wrap.hour_chime", 32'(bus.hour_chime), 1);
        check("wrap.sec_tick", 32'(bus.sec_tick), 1);
        step(1);
        check("wrap.day_wrap_off", 32'(bus.day_wrap), 0);
        check("wrap.chime_off", 32'(bus.hour_chime), 0);

        // Mode toggle with time frozen
        bus.run = 1'b0;
        load(5'd13, 6'd5, 6'd0);
        check_time("m12", 1, 5, 0);
        check("m12.isPM", 32'(bus.isPM), 1);
        bus.mode24 = 1'b1;
        step(1);
        check_time("m24", 13, 5, 0);
        check("m24.isPM", 32'(bus.isPM), 1);
        bus.mode24 = 1'b0;
        step(1);
        check_time("m12b", 1, 5, 0);

        // Rejected loads
        load(5'd10, 6'd60, 6'd0);
        check("rej_min.set_err", 32'(bus.set_err), 1);
        check_time("rej_min", 1, 5, 0);
        step(1);
        check("rej_min.err_off", 32'(bus.set_err), 0);
        load(5'd24, 6'd0, 6'd0);
        check("rej_hr.set_err", 32'(bus.set_err), 1);
        check_time("rej_hr", 1, 5, 0);
        load(5'd1, 6'd1, 6'd60);
        check("rej_sec.set_err", 32'(bus.set_err), 1);

        // Accepted load coincident with a tick: load wins
        bus.run = 1'b1;
        step(3);
        load(5'd7, 6'd0, 6'd0);
        check_time("ldtick", 7, 0, 0);
        check("ldtick.sec_tick", 32'(bus.sec_tick), 0);
        check("ldtick.chime", 32'(bus.hour_chime), 0);
        step(3);
        check("ldtick.quiet", 32'(bus.seconds), 0);
        step(1);
        check("ldtick.next", 32'(bus.seconds), 1);
        check("ldtick.next_tick", 32'(bus.sec_tick), 1);

        // Rejected load coincident with a tick: tick proceeds
        step(3);
        load(5'd7, 6'd60, 6'd0);
        check_time("rejtick", 7, 0, 2);
        check("rejtick.sec_tick", 32'(bus.sec_tick), 1);
        check("rejtick.set_err", 32'(bus.set_err), 1);

        // Alarm at 06:30
        bus.alarm_en      = 1'b1;
        bus.alarm_hours   = 5'd6;
        bus.alarm_minutes = 6'd30;
        load(5'd6, 6'd29, 6'd59);
        check("al.load_quiet", 32'(bus.alarm), 0);
        step(3);
        check("al.before", 32'(bus.alarm), 0);
        step(1);
        check_time("al", 6, 30, 0);
        check("al.alarm", 32'(bus.alarm), 1);
        check("al.sec_tick", 32'(bus.sec_tick), 1);
        check("al.chime", 32'(bus.hour_chime), 0);
        step(1);
        check("al.off", 32'(bus.alarm), 0);
        load(5'd6, 6'd30, 6'd0);
        check("al.direct", 32'(bus.alarm), 0);

        // Disabled alarm does not fire
        bus.alarm_en = 1'b0;
        load(5'd6, 6'd29, 6'd59);
        step(4);
        check_time("aldis", 6, 30, 0);
        check("aldis.alarm", 32'(bus.alarm), 0);

        // Pause at prescaler=2 and resume
        load(5'd6, 6'd30, 6'd0);
        step(2);
        bus.run  = 1'b0;
        saw_tick = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (bus.sec_tick) saw_tick = 1'b1;
        end
        check("pause.no_tick", 32'(saw_tick), 0);
        check_time("pause", 6, 30, 0);
        bus.run = 1'b1;
        step(1);
        check("resume.wait", 32'(bus.sec_tick), 0);
        step(1);
        check("resume.tick", 32'(bus.sec_tick), 1);
        check("resume.seconds", 32'(bus.seconds), 1);

        // Reset overrides a simultaneous load
        reset         = 1'b1;
        bus.set_valid = 1'b1;
        bus.set_hours = 5'd15;
        step(1);
        reset         = 1'b0;
        bus.set_valid = 1'b0;
        bus.run       = 1'b0;
        check_time("rst2", 12, 0, 0);
        check("rst2.isPM", 32'(bus.isPM), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_clock_core.md
# rtc_clock_core

Parametrised successor to the team's fixed 12-hour seconds/minutes/hours counter. Adds a configurable clock prescaler, run/pause control, a runtime-selectable 12/24-hour display mode, a validated time-load port, and a minute-resolution alarm. It is the timekeeping core feeding the display and alarm logic in the clock design.

## Interface
- TICKS_PER_SEC, default 1000, number of `clk` cycles per second; must be ≥1.
- DEFAULT_24H, default 0, display mode loaded at reset (0 = 12-hour, 1 = 24-hour).
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = prescaler counts; 0 = time frozen, prescaler holds.
- mode24  in  1  display mode request; registered into mode_reg every cycle.
- set_valid  in  1  one-cycle time-load strobe.
- set_hours  in  5  load value, always 24-hour format (0–23).
- set_minutes  in  6  load value (0–59).
- set_seconds  in  6  load value (0–59).
- alarm_en  in  1  alarm enable.
- alarm_hours  in  5  alarm hour, 24-hour format.
- alarm_minutes  in  6  alarm minute.
- seconds  out  6  current seconds (0–59).
- minutes  out  6  current minutes (0–59).
- hours  out  5  display hour: 0–23 in 24-hour mode, 1–12 in 12-hour mode.
- isPM  out  1  1 when internal hour24 ≥ 12, in both modes.
- sec_tick  out  1  one-cycle pulse coincident with each tick-driven time advance.
- hour_chime  out  1  one-cycle pulse when a tick produces mm:ss = 00:00.
- day_wrap  out  1  one-cycle pulse when a tick wraps 23:59:59 to 00:00:00.
- set_err  out  1  one-cycle pulse when a load is rejected.
- alarm  out  1  one-cycle pulse when the alarm matches.

## Operation
- Internal state: prescaler (width $clog2(TICKS_PER_SEC), min 1), sec, min, hour24 (0–23), mode_reg, and registered pulse outputs.
- Prescaler:
  - While run=1, counts 0..TICKS_PER_SEC-1.
  - At terminal count it wraps to 0 and a tick occurs.
  - With TICKS_PER_SEC=1, a tick occurs every run cycle.
- Tick: sec+1. When sec=59: sec=0 and min+1. When min=59: min=0 and hour24+1. When hour24=23: hour24=0.
- Pulses, registered and high in the same cycle the new time is visible:
  - sec_tick on every tick.
  - hour_chime when the new min=0 and sec=0.
  - day_wrap when the new time is 00:00:00.
  - alarm when alarm_en=1 and the new time equals alarm_hours:alarm_minutes:00.
- Display mapping (combinational from registered state):
  - 24-hour mode: hours = hour24.
  - 12-hour mode: hours = hour24 mod 12, with 0 mapped to 12.
  - isPM = (hour24 ≥ 12).
- Load:
  - set_valid with set_hours ≤ 23, set_minutes ≤ 59 and set_seconds ≤ 59 loads all three fields and clears the prescaler to 0.
  - Any out-of-range field rejects the whole load: time unchanged, prescaler unchanged, set_err=1 next cycle.
  - A load, accepted or rejected, never asserts sec_tick, hour_chime, day_wrap or alarm.
- Load versus tick in the same cycle: the load wins. An accepted load suppresses the tick and its pulses. A rejected load lets the tick proceed normally.
- Loads are accepted whether run is 0 or 1.
- An alarm time that is out of range never matches. No error is flagged for it.

## Timing
- Reset (synchronous, the edge where reset=1):
  - prescaler=0, sec=0, min=0, hour24=0, mode_reg=DEFAULT_24H.
  - All pulse outputs 0.
  - Outputs: seconds=0, minutes=0, isPM=0, hours=12 (12-hour) or 0 (24-hour).
- Reset overrides set_valid, run and any tick in the same cycle.
- First tick after reset is released with run=1: TICKS_PER_SEC rising edges after the first non-reset edge, seconds becomes 1 with sec_tick=1.
- Accepted load: new time visible 1 cycle after set_valid. The next tick follows TICKS_PER_SEC run cycles later.
- mode24 change: hours reformatted 1 cycle later. Time state is unaffected.
- run=0 freezes the prescaler. Resuming continues from the held count, with no lost or extra tick.
- Every pulse is exactly 1 cycle wide. Pulses that fire together appear in the same cycle.

## Test plan
- TICKS_PER_SEC=4, DEFAULT_24H=0, reset then run=1 → hours=12, isPM=0. Seconds step 0→1→2 every 4 cycles, with sec_tick high in those cycles.
- Load 23:59:58, run=1 → after 2 ticks time=00:00:00. day_wrap and hour_chime both pulse once; hours=12 (12-hour), isPM goes 1→0.
- Load 13:05:00, toggle mode24 0→1→0 → hours 1→13→1. isPM stays 1 throughout; seconds and minutes unchanged.
- Load set_minutes=60 → set_err pulses once, time unchanged. Load 07:00:00 in the same cycle as a tick → time=07:00:00, no sec_tick.
- alarm_en=1, alarm 06:30, load 06:29:59 → alarm pulses on the next tick. Loading 06:30:00 directly gives no alarm.
- run=0 for 10 cycles at prescaler=2 (TICKS=4) → time and prescaler frozen. After run=1 the next tick arrives 2 cycles later.
